// File: rtl/player_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : player_ctrl_multi
// Purpose  : Per-player movement / bomb-request controller for NUM_PLAYERS
//            players on a GRID_W x GRID_H board. Each player has a
//            ready/valid request port with a move cooldown, wall and
//            player-to-player collision, kill/alive state and bomb-capacity
//            power-ups.
// Options  : define PCTRL_WRAP_EN for a toroidal board (edge moves wrap to
//            the opposite edge); undefined, edge moves are blocked.
// Revision : 1.0 - initial release
// ============================================================================
module player_ctrl_multi #(
    parameter int NUM_PLAYERS   = 2,
    parameter int GRID_W        = 16,
    parameter int GRID_H        = 16,
    parameter int MOVE_COOLDOWN = 3,
    parameter int BOMB_MAX_INIT = 1,
    parameter int BOMB_MAX_CAP  = 7,
    localparam int CW = $clog2((GRID_W > GRID_H) ? GRID_W : GRID_H)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PLAYERS-1:0]      in_valid_i,
    output logic [NUM_PLAYERS-1:0]      in_ready_o,
    input  logic [3*NUM_PLAYERS-1:0]    dir_i,
    input  logic [NUM_PLAYERS-1:0]      bomb_req_i,
    input  logic [3*NUM_PLAYERS-1:0]    bomb_num_i,
    input  logic [NUM_PLAYERS-1:0]      powerup_inc_i,
    input  logic [NUM_PLAYERS-1:0]      kill_i,
    input  logic [GRID_W*GRID_H-1:0]    wall_i,
    output logic [CW*NUM_PLAYERS-1:0]   pos_x_o,
    output logic [CW*NUM_PLAYERS-1:0]   pos_y_o,
    output logic [2*NUM_PLAYERS-1:0]    face_dir_o,
    output logic [NUM_PLAYERS-1:0]      alive_o,
    output logic [NUM_PLAYERS-1:0]      set_bomb_o,
    output logic [CW*NUM_PLAYERS-1:0]   bomb_x_o,
    output logic [CW*NUM_PLAYERS-1:0]   bomb_y_o,
    output logic [3*NUM_PLAYERS-1:0]    bomb_max_o
);

    // Cell index arithmetic carries one spare bit so y*GRID_W + x never wraps.
    localparam int NCELL = GRID_W * GRID_H;
    localparam int IW    = $clog2(NCELL) + 1;
    localparam int IDXW  = $clog2(NCELL);
    localparam int CNTW  = (MOVE_COOLDOWN > 0) ? $clog2(MOVE_COOLDOWN + 1) : 1;

    localparam logic [CW-1:0]   C_XMAX      = CW'(GRID_W - 1);
    localparam logic [CW-1:0]   C_YMAX      = CW'(GRID_H - 1);
    localparam logic [2:0]      C_BMAX_INIT = 3'(BOMB_MAX_INIT);
    localparam logic [2:0]      C_BMAX_CAP  = 3'(BOMB_MAX_CAP);
    localparam logic [CNTW-1:0] C_COOL      = CNTW'(MOVE_COOLDOWN);
    localparam logic [IW-1:0]   C_NCELL     = IW'(NCELL);

    localparam logic [2:0] C_DIR_UP    = 3'd0;
    localparam logic [2:0] C_DIR_DOWN  = 3'd1;
    localparam logic [2:0] C_DIR_LEFT  = 3'd2;
    localparam logic [2:0] C_DIR_RIGHT = 3'd3;

    typedef enum logic [1:0] {
        ST_READY = 2'd0,
        ST_COOL  = 2'd1,
        ST_DEAD  = 2'd2
    } state_e;

    // Registered per-player state
    state_e          state_q    [NUM_PLAYERS];
    logic [CNTW-1:0] cnt_q      [NUM_PLAYERS];
    logic [CW-1:0]   pos_x_q    [NUM_PLAYERS];
    logic [CW-1:0]   pos_y_q    [NUM_PLAYERS];
    logic [1:0]      face_q     [NUM_PLAYERS];
    logic            set_bomb_q [NUM_PLAYERS];
    logic [CW-1:0]   bomb_x_q   [NUM_PLAYERS];
    logic [CW-1:0]   bomb_y_q   [NUM_PLAYERS];
    logic [2:0]      bomb_max_q [NUM_PLAYERS];

    // Combinational move evaluation
    logic            w_alive    [NUM_PLAYERS];
    logic            w_accept   [NUM_PLAYERS];
    logic [2:0]      w_dir      [NUM_PLAYERS];
    logic            w_has_tgt  [NUM_PLAYERS];
    logic            w_claim    [NUM_PLAYERS];
    logic [CW-1:0]   w_tgt_x    [NUM_PLAYERS];
    logic [CW-1:0]   w_tgt_y    [NUM_PLAYERS];
    logic [IW-1:0]   w_idx      [NUM_PLAYERS];
    logic            w_blocked  [NUM_PLAYERS];
    logic [CW-1:0]   pos_x_d    [NUM_PLAYERS];
    logic [CW-1:0]   pos_y_d    [NUM_PLAYERS];

    function automatic logic [CW-1:0] start_x(input int p);
        return (p == 1 || p == 2) ? C_XMAX : '0;
    endfunction

    function automatic logic [CW-1:0] start_y(input int p);
        return (p == 1 || p == 3) ? C_YMAX : '0;
    endfunction

    // Target cell, blocking rules and next position for every player
    always_comb begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            w_alive[i]   = (state_q[i] != ST_DEAD);
            w_accept[i]  = in_valid_i[i] && (state_q[i] == ST_READY);
            w_dir[i]     = dir_i[3*i +: 3];
            w_has_tgt[i] = 1'b0;
            w_tgt_x[i]   = pos_x_q[i];
            w_tgt_y[i]   = pos_y_q[i];
            case (w_dir[i])
                C_DIR_UP: begin
                    if (pos_y_q[i] != '0) begin
                        w_has_tgt[i] = 1'b1;
                        w_tgt_y[i]   = pos_y_q[i] - CW'(1);
                    end else begin
`ifdef PCTRL_WRAP_EN
                        w_has_tgt[i] = 1'b1;
                        w_tgt_y[i]   = C_YMAX;
`endif
                    end
                end
                C_DIR_DOWN: begin
                    if (pos_y_q[i] != C_YMAX) begin
                        w_has_tgt[i] = 1'b1;
                        w_tgt_y[i]   = pos_y_q[i] + CW'(1);
                    end else begin
`ifdef PCTRL_WRAP_EN
                        w_has_tgt[i] = 1'b1;
                        w_tgt_y[i]   = '0;
`endif
                    end
                end
                C_DIR_LEFT: begin
                    if (pos_x_q[i] != '0) begin
                        w_has_tgt[i] = 1'b1;
                        w_tgt_x[i]   = pos_x_q[i] - CW'(1);
                    end else begin
`ifdef PCTRL_WRAP_EN
                        w_has_tgt[i] = 1'b1;
                        w_tgt_x[i]   = C_XMAX;
`endif
                    end
                end
                C_DIR_RIGHT: begin
                    if (pos_x_q[i] != C_XMAX) begin
                        w_has_tgt[i] = 1'b1;
                        w_tgt_x[i]   = pos_x_q[i] + CW'(1);
                    end else begin
`ifdef PCTRL_WRAP_EN
                        w_has_tgt[i] = 1'b1;
                        w_tgt_x[i]   = '0;
`endif
                    end
                end
                default: begin
                    // STOP and the unused codes leave the player in place.
                    w_has_tgt[i] = 1'b0;
                end
            endcase
            // A lower-index player claims its target cell whenever its move is
            // accepted and not overridden by a kill, even if it ends up blocked.
            w_claim[i] = w_accept[i] && w_has_tgt[i] && !kill_i[i];
            w_idx[i]   = IW'(w_tgt_y[i]) * IW'(GRID_W) + IW'(w_tgt_x[i]);
        end

        for (int i = 0; i < NUM_PLAYERS; i++) begin
            w_blocked[i] = !w_has_tgt[i];
            if (w_idx[i] < C_NCELL) begin
                if (wall_i[w_idx[i][IDXW-1:0]]) begin
                    w_blocked[i] = 1'b1;
                end
            end
            for (int j = 0; j < NUM_PLAYERS; j++) begin
                if (j != i) begin
                    if (w_alive[j] && pos_x_q[j] == w_tgt_x[i] && pos_y_q[j] == w_tgt_y[i]) begin
                        w_blocked[i] = 1'b1;
                    end
                    if (j < i && w_claim[j] && w_tgt_x[j] == w_tgt_x[i] && w_tgt_y[j] == w_tgt_y[i]) begin
                        w_blocked[i] = 1'b1;
                    end
                end
            end
            pos_x_d[i] = (w_accept[i] && !w_blocked[i]) ? w_tgt_x[i] : pos_x_q[i];
            pos_y_d[i] = (w_accept[i] && !w_blocked[i]) ? w_tgt_y[i] : pos_y_q[i];
        end
    end

    // Per-player READY/COOL/DEAD FSM with registered position, facing and bomb outputs
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (!rst_n) begin
                state_q[i]    <= ST_READY;
                cnt_q[i]      <= '0;
                pos_x_q[i]    <= start_x(i);
                pos_y_q[i]    <= start_y(i);
                face_q[i]     <= 2'd0;
                set_bomb_q[i] <= 1'b0;
                bomb_x_q[i]   <= '0;
                bomb_y_q[i]   <= '0;
                bomb_max_q[i] <= C_BMAX_INIT;
            end else begin
                set_bomb_q[i] <= 1'b0;
                case (state_q[i])
                    ST_DEAD: begin
                        // Frozen until reset.
                        cnt_q[i] <= '0;
                    end
                    default: begin
                        if (kill_i[i]) begin
                            // Kill overrides any request in the same cycle.
                            state_q[i] <= ST_DEAD;
                            cnt_q[i]   <= '0;
                        end else begin
                            if (powerup_inc_i[i] && bomb_max_q[i] < C_BMAX_CAP) begin
                                bomb_max_q[i] <= bomb_max_q[i] + 3'd1;
                            end
                            pos_x_q[i] <= pos_x_d[i];
                            pos_y_q[i] <= pos_y_d[i];
                            if (w_accept[i]) begin
                                if (w_dir[i] < 3'd4) begin
                                    face_q[i] <= w_dir[i][1:0];
                                end
                                if (bomb_req_i[i] && bomb_num_i[3*i +: 3] < bomb_max_q[i]) begin
                                    set_bomb_q[i] <= 1'b1;
                                    bomb_x_q[i]   <= pos_x_q[i];
                                    bomb_y_q[i]   <= pos_y_q[i];
                                end
                                if (MOVE_COOLDOWN > 0) begin
                                    state_q[i] <= ST_COOL;
                                    cnt_q[i]   <= C_COOL;
                                end
                            end else if (state_q[i] == ST_COOL) begin
                                if (cnt_q[i] <= CNTW'(1)) begin
                                    state_q[i] <= ST_READY;
                                    cnt_q[i]   <= '0;
                                end else begin
                                    cnt_q[i] <= cnt_q[i] - CNTW'(1);
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    // Flatten per-player registers onto the packed output buses
    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_out
        assign in_ready_o[p]           = (state_q[p] == ST_READY);
        assign alive_o[p]              = (state_q[p] != ST_DEAD);
        assign set_bomb_o[p]           = set_bomb_q[p];
        assign pos_x_o[CW*p +: CW]     = pos_x_q[p];
        assign pos_y_o[CW*p +: CW]     = pos_y_q[p];
        assign bomb_x_o[CW*p +: CW]    = bomb_x_q[p];
        assign bomb_y_o[CW*p +: CW]    = bomb_y_q[p];
        assign face_dir_o[2*p +: 2]    = face_q[p];
        assign bomb_max_o[3*p +: 3]    = bomb_max_q[p];
    end

endmodule
`default_nettype wire

// File: tb/tb_player_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_player_ctrl_multi
// Purpose  : Self-checking bench for player_ctrl_multi (2 players, 16x16,
//            cooldown 3, default build without board wrap).
// Revision : 1.0 - initial release
// ============================================================================
module tb_player_ctrl_multi;

    localparam int NP = 2;
    localparam int CW = 4;

    localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3, STOP = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP-1:0]     in_valid;
    logic [NP-1:0]     in_ready;
    logic [3*NP-1:0]   dir;
    logic [NP-1:0]     bomb_req;
    logic [3*NP-1:0]   bomb_num;
    logic [NP-1:0]     powerup_inc;
    logic [NP-1:0]     kill;
    logic [255:0]      wall;
    logic [CW*NP-1:0]  pos_x;
    logic [CW*NP-1:0]  pos_y;
    logic [2*NP-1:0]   face_dir;
    logic [NP-1:0]     alive;
    logic [NP-1:0]     set_bomb;
    logic [CW*NP-1:0]  bomb_x;
    logic [CW*NP-1:0]  bomb_y;
    logic [3*NP-1:0]   bomb_max;

    player_ctrl_multi dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .dir_i         (dir),
        .bomb_req_i    (bomb_req),
        .bomb_num_i    (bomb_num),
        .powerup_inc_i (powerup_inc),
        .kill_i        (kill),
        .wall_i        (wall),
        .pos_x_o       (pos_x),
        .pos_y_o       (pos_y),
        .face_dir_o    (face_dir),
        .alive_o       (alive),
        .set_bomb_o    (set_bomb),
        .bomb_x_o      (bomb_x),
        .bomb_y_o      (bomb_y),
        .bomb_max_o    (bomb_max)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int v;
        int d;
        int br;
        int bn;
        int ex;
        int ey;
        int ef;
        int er;
        int esb;
    } vec_t;

    vec_t tbl [17];
    vec_t sbq [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int px(input int p);
        return int'(pos_x[CW*p +: CW]);
    endfunction
    function automatic int py(input int p);
        return int'(pos_y[CW*p +: CW]);
    endfunction
    function automatic int pf(input int p);
        return int'(face_dir[2*p +: 2]);
    endfunction
    function automatic int pbm(input int p);
        return int'(bomb_max[3*p +: 3]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        in_valid    = '0;
        bomb_req    = '0;
        powerup_inc = '0;
        kill        = '0;
        bomb_num    = '0;
        dir         = {3'd4, 3'd4};
    endtask

    task automatic do_reset();
        clr();
        rst_n = 1'b0;
        tick();
        tick();
    endtask

    task automatic wait_ready2();
        int n = 0;
        while (!(in_ready[0] && in_ready[1]) && n < 20) begin
            tick();
            n++;
        end
        if (!(in_ready[0] && in_ready[1])) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=%0d expected=3", in_ready);
        end
    endtask

    // One accepted request per player (valid flags v0/v1), then return to idle.
    task automatic go2(input int v0, input int d0, input int v1, input int d1);
        wait_ready2();
        in_valid[0] = v0[0];
        in_valid[1] = v1[0];
        dir[2:0]    = 3'(d0);
        dir[5:3]    = 3'(d1);
        tick();
        clr();
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_p0x"}, px(0), 0);
        chk({tag, "_p0y"}, py(0), 0);
        chk({tag, "_p1x"}, px(1), 15);
        chk({tag, "_p1y"}, py(1), 15);
        chk({tag, "_face"}, int'(face_dir), 0);
        chk({tag, "_alive"}, int'(alive), 3);
        chk({tag, "_ready"}, int'(in_ready), 3);
        chk({tag, "_setb"}, int'(set_bomb), 0);
        chk({tag, "_bmax0"}, pbm(0), 1);
        chk({tag, "_bmax1"}, pbm(1), 1);
    endtask

    initial begin
        wall = '0;
        do_reset();
        chk_reset_state("rst");
        chk("rst_bx", int'(bomb_x), 0);
        chk("rst_by", int'(bomb_y), 0);
        rst_n = 1'b1;

        // P0 stimulus and expected P0 state one edge later
        //          v  d  br bn  ex ey ef er esb
        tbl[0]  = '{1, 1, 0, 0,  0, 1, 1, 0, 0};
        tbl[1]  = '{1, 1, 0, 0,  0, 1, 1, 0, 0};
        tbl[2]  = '{0, 4, 0, 0,  0, 1, 1, 0, 0};
        tbl[3]  = '{0, 4, 0, 0,  0, 1, 1, 1, 0};
        tbl[4]  = '{1, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[5]  = '{0, 4, 0, 0,  0, 0, 0, 0, 0};
        tbl[6]  = '{0, 4, 0, 0,  0, 0, 0, 0, 0};
        tbl[7]  = '{0, 4, 0, 0,  0, 0, 0, 1, 0};
        tbl[8]  = '{1, 2, 0, 0,  0, 0, 2, 0, 0};
        tbl[9]  = '{0, 4, 0, 0,  0, 0, 2, 0, 0};
        tbl[10] = '{0, 4, 0, 0,  0, 0, 2, 0, 0};
        tbl[11] = '{0, 4, 0, 0,  0, 0, 2, 1, 0};
        tbl[12] = '{1, 4, 1, 0,  0, 0, 2, 0, 1};
        tbl[13] = '{0, 4, 0, 0,  0, 0, 2, 0, 0};
        tbl[14] = '{0, 4, 0, 0,  0, 0, 2, 0, 0};
        tbl[15] = '{0, 4, 0, 0,  0, 0, 2, 1, 0};
        tbl[16] = '{1, 7, 0, 0,  0, 0, 2, 0, 0};

        for (int i = 0; i < 17; i++) begin
            vec_t e;
            in_valid[0] = tbl[i].v[0];
            dir[2:0]    = 3'(tbl[i].d);
            bomb_req[0] = tbl[i].br[0];
            bomb_num[2:0] = 3'(tbl[i].bn);
            sbq.push_back(tbl[i]);
            tick();
            clr();
            e = sbq.pop_front();
            chk($sformatf("row%0d_x", i), px(0), e.ex);
            chk($sformatf("row%0d_y", i), py(0), e.ey);
            chk($sformatf("row%0d_face", i), pf(0), e.ef);
            chk($sformatf("row%0d_ready", i), int'(in_ready[0]), e.er);
            chk($sformatf("row%0d_setb", i), int'(set_bomb[0]), e.esb);
        end

        // Walk P0 to (3,4), then a blocked RIGHT into a wall with a bomb request
        for (int k = 0; k < 7; k++) go2(1, (k < 3) ? RIGHT : DOWN, 0, STOP);
        wait_ready2();
        wall[4*16 + 4] = 1'b1;
        in_valid[0] = 1'b1;
        dir[2:0]    = 3'(RIGHT);
        bomb_req[0] = 1'b1;
        tick();
        clr();
        chk("wall_x", px(0), 3);
        chk("wall_y", py(0), 4);
        chk("wall_face", pf(0), 3);
        chk("bomb_strobe", int'(set_bomb[0]), 1);
        chk("bomb_x", int'(bomb_x[3:0]), 3);
        chk("bomb_y", int'(bomb_y[3:0]), 4);
        tick();
        chk("bomb_strobe_end", int'(set_bomb[0]), 0);
        wait_ready2();
        in_valid[0]   = 1'b1;
        bomb_req[0]   = 1'b1;
        bomb_num[2:0] = 3'd1;
        tick();
        clr();
        chk("bomb_full", int'(set_bomb[0]), 0);
        chk("bomb_full_ready", int'(in_ready[0]), 0);
        wall = '0;

        // Reset while P0 is cooling down
        do_reset();
        chk_reset_state("rst_mid");
        rst_n = 1'b1;

        // Bring P0 to (5,5) and P1 to (7,5), then contend for (6,5)
        for (int k = 0; k < 18; k++) go2((k < 10) ? 1 : 0, (k < 5) ? RIGHT : DOWN, 1, (k < 8) ? LEFT : UP);
        chk("walk_p0x", px(0), 5);
        chk("walk_p0y", py(0), 5);
        chk("walk_p1x", px(1), 7);
        chk("walk_p1y", py(1), 5);
        go2(1, RIGHT, 1, LEFT);
        chk("tie_p0x", px(0), 6);
        chk("tie_p0face", pf(0), 3);
        chk("tie_p1x", px(1), 7);
        chk("tie_p1y", py(1), 5);
        chk("tie_p1face", pf(1), 2);
        go2(1, RIGHT, 0, STOP);
        chk("occupied_p0x", px(0), 6);

        // Power-ups on P1 saturate at the cap
        powerup_inc[1] = 1'b1;
        tick();
        chk("pwr_first", pbm(1), 2);
        for (int k = 0; k < 9; k++) tick();
        clr();
        chk("pwr_sat", pbm(1), 7);
        chk("pwr_p0", pbm(0), 1);

        // Kill P1 together with an accepted move
        wait_ready2();
        in_valid[1] = 1'b1;
        dir[5:3]    = 3'(UP);
        kill[1]     = 1'b1;
        tick();
        clr();
        chk("kill_alive", int'(alive[1]), 0);
        chk("kill_p1y", py(1), 5);
        chk("kill_ready", int'(in_ready[1]), 0);
        chk("kill_p0alive", int'(alive[0]), 1);

        // A dead player no longer blocks P0
        begin
            int n = 0;
            while (!in_ready[0] && n < 20) begin
                tick();
                n++;
            end
            chk("p0_ready_wait", int'(in_ready[0]), 1);
        end
        in_valid[0] = 1'b1;
        dir[2:0]    = 3'(RIGHT);
        tick();
        clr();
        chk("dead_noblock_x", px(0), 7);
        for (int k = 0; k < 8; k++) tick();
        chk("dead_ready_hold", int'(in_ready[1]), 0);
        chk("dead_alive_hold", int'(alive[1]), 0);

        do_reset();
        chk_reset_state("rst_end");
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case a loop above never returns
    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0d expected=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
